// File: rtl/ninety_nine_to_zero_pkg.sv
// Shared types and helpers for the two-digit BCD countdown timer.
package bcd_timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} timer_state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/ninety_nine_to_zero_decade_down_ctr.sv
// Single BCD decade down-counter with parallel load and combinational borrow-out.
module decade_down_ctr
  import bcd_timer_pkg::*;
#(
  parameter logic [3:0] RESET_VAL = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec_en,
  output logic [3:0] dcba,
  output logic       bout
);

  // Wrap 0 -> 9; an out-of-range digit also lands on 9.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcba <= RESET_VAL;
    end else if (load) begin
      dcba <= load_val;
    end else if (dec_en) begin
      dcba <= ((dcba == 4'd0) || (dcba > BCD_MAX)) ? BCD_MAX : (dcba - 4'd1);
    end
  end

  assign bout = dec_en & (dcba == 4'd0);

endmodule

// File: rtl/ninety_nine_to_zero.sv
// Two-digit BCD countdown timer with load, start/stop, expiry pulse and optional auto-reload.
module ninety_nine_to_zero
  import bcd_timer_pkg::*;
#(
  parameter bit         AUTO_RELOAD = 1'b0,
  parameter logic [3:0] RESET_TENS  = 4'd9,
  parameter logic [3:0] RESET_ONES  = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  input  logic       start,
  input  logic       stop,
  input  logic       count_en,
  output logic [3:0] dcba10,
  output logic [3:0] dcba1,
  output logic       zero,
  output logic       busy,
  output logic       done,
  output logic       load_err
);

  timer_state_t state, state_n;
  logic [3:0]   shadow_tens, shadow_ones;
  logic         ones_dec, ones_bout, tens_bout;
  logic         reload, ctr_load, expire;
  logic [3:0]   tens_load_val, ones_load_val;

  assign zero = (dcba10 == 4'd0) && (dcba1 == 4'd0);
  assign busy = (state == RUN);

  // Decrement only when nothing of higher priority is active and the value is above 00.
  assign ones_dec = (state == RUN) & count_en & ~load & ~stop & ~zero;
  assign expire   = ones_dec & (dcba10 == 4'd0) & (dcba1 == 4'd1);

  assign reload   = AUTO_RELOAD & (state == EXPIRED) & ~load &
                    ((shadow_tens != 4'd0) || (shadow_ones != 4'd0));
  assign ctr_load = load | reload;

  assign tens_load_val = load ? bcd_clamp(load_tens) : shadow_tens;
  assign ones_load_val = load ? bcd_clamp(load_ones) : shadow_ones;

  decade_down_ctr #(.RESET_VAL(RESET_ONES)) u_ones (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .load_val (ones_load_val),
    .dec_en   (ones_dec),
    .dcba     (dcba1),
    .bout     (ones_bout)
  );

  decade_down_ctr #(.RESET_VAL(RESET_TENS)) u_tens (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .load_val (tens_load_val),
    .dec_en   (ones_bout),
    .dcba     (dcba10),
    .bout     (tens_bout)
  );

  always_comb begin
    state_n = state;
    if (load) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start) state_n = zero ? EXPIRED : RUN;
        RUN:     if (stop) state_n = IDLE;
                 else if (expire) state_n = EXPIRED;
        EXPIRED: state_n = reload ? RUN : IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // done trails the single EXPIRED cycle by one register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shadow_tens <= RESET_TENS;
      shadow_ones <= RESET_ONES;
      done        <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      state    <= state_n;
      done     <= (state == EXPIRED);
      load_err <= load & ((load_tens > BCD_MAX) | (load_ones > BCD_MAX));
      if (load) begin
        shadow_tens <= bcd_clamp(load_tens);
        shadow_ones <= bcd_clamp(load_ones);
      end
    end
  end

  logic unused_ok;
  assign unused_ok = tens_bout;

endmodule

// File: tb/tb_ninety_nine_to_zero.sv
// Randomized and directed bench for the BCD countdown timer, with and without auto-reload.
module tb_ninety_nine_to_zero;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0, start = 1'b0, stop = 1'b0, count_en = 1'b0;
  logic [3:0] load_tens = 4'd0, load_ones = 4'd0;

  logic [3:0] t0, o0, t1, o1;
  logic       z0, b0, d0, e0, z1, b1, d1, e1;

  int errors = 0;
  int checks = 0;

  // Reference state per instance: index 0 no reload, index 1 auto-reload.
  // State codes: 0 idle, 1 running, 2 expired.
  int m_val[2], m_sh[2], m_st[2], m_done[2], m_lerr[2];

  always #5 clk = ~clk;

  ninety_nine_to_zero #(.AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .load(load), .load_tens(load_tens), .load_ones(load_ones),
    .start(start), .stop(stop), .count_en(count_en),
    .dcba10(t0), .dcba1(o0), .zero(z0), .busy(b0), .done(d0), .load_err(e0)
  );

  ninety_nine_to_zero #(.AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .load_tens(load_tens), .load_ones(load_ones),
    .start(start), .stop(stop), .count_en(count_en),
    .dcba10(t1), .dcba1(o1), .zero(z1), .busy(b1), .done(d1), .load_err(e1)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp9(input int d);
    return (d > 9) ? 9 : d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_val[i] = 99; m_sh[i] = 99; m_st[i] = 0; m_done[i] = 0; m_lerr[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    int lt, lo;
    lt = int'(load_tens);
    lo = int'(load_ones);
    m_done[i] = (m_st[i] == 2) ? 1 : 0;
    m_lerr[i] = (load && (lt > 9 || lo > 9)) ? 1 : 0;
    if (load) begin
      m_val[i] = clamp9(lt) * 10 + clamp9(lo);
      m_sh[i]  = m_val[i];
      m_st[i]  = 0;
    end else if (m_st[i] == 0) begin
      if (start) m_st[i] = (m_val[i] == 0) ? 2 : 1;
    end else if (m_st[i] == 1) begin
      if (stop) m_st[i] = 0;
      else if (count_en && m_val[i] > 0) begin
        m_val[i] = m_val[i] - 1;
        if (m_val[i] == 0) m_st[i] = 2;
      end
    end else begin
      if (i == 1 && m_sh[i] != 0) begin
        m_val[i] = m_sh[i];
        m_st[i]  = 1;
      end else begin
        m_st[i] = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst) model_reset();
    else for (int i = 0; i < 2; i++) model_step(i);
  end

  task automatic check_dut(input int i, input logic [3:0] t, input logic [3:0] o,
                           input logic z, input logic b, input logic d, input logic e);
    string p;
    p = (i == 0) ? "plain" : "reload";
    chk({p, ".tens"}, int'(t), m_val[i] / 10);
    chk({p, ".ones"}, int'(o), m_val[i] % 10);
    chk({p, ".zero"}, int'(z), (m_val[i] == 0) ? 1 : 0);
    chk({p, ".busy"}, int'(b), (m_st[i] == 1) ? 1 : 0);
    chk({p, ".done"}, int'(d), m_done[i]);
    chk({p, ".load_err"}, int'(e), m_lerr[i]);
  endtask

  task automatic check_all();
    check_dut(0, t0, o0, z0, b0, d0, e0);
    check_dut(1, t1, o1, z1, b1, d1, e1);
  endtask

  task automatic cyc(input logic l, input int lt, input int lo,
                     input logic s, input logic sp, input logic ce);
    load = l; load_tens = 4'(lt); load_ones = 4'(lo);
    start = s; stop = sp; count_en = ce;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int n, dones;
    bit found;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    chk("reset.tens", int'(t0), 9);
    chk("reset.ones", int'(o0), 9);
    chk("reset.busy", int'(b0), 0);
    chk("reset.done", int'(d0), 0);
    rst = 1'b0;

    // Load 21 and count down to expiry.
    cyc(1, 2, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 1);
    n = 0; found = 0;
    for (int k = 1; k <= 40 && !found; k++) begin
      cyc(0, 0, 0, 0, 0, 1);
      if (d0) begin found = 1; n = k; end
    end
    chk("done_latency", n, 22);
    chk("after_done.busy", int'(b0), 0);
    chk("after_done.value", int'(t0) * 10 + int'(o0), 0);

    // Out-of-range tens digit is clamped and flagged.
    cyc(1, 12, 3, 0, 0, 0);
    chk("clamp.value", int'(t0) * 10 + int'(o0), 93);
    chk("clamp.load_err", int'(e0), 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("clamp.load_err_drop", int'(e0), 0);

    // Auto-reload from 03 runs continuously; loading 00 aborts it.
    cyc(1, 0, 3, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 1);
    dones = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc(0, 0, 0, 0, 0, 1);
      if (d1) dones++;
    end
    chk("reload.dones", dones, 3);
    chk("reload.value", int'(t1) * 10 + int'(o1), 3);
    cyc(1, 0, 0, 0, 0, 1);
    dones = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc(0, 0, 0, 0, 0, 1);
      if (d1) dones++;
    end
    chk("reload.abort_dones", dones, 0);

    // count_en gating and stop.
    cyc(1, 5, 7, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1); chk("gate.1", int'(t0) * 10 + int'(o0), 56);
    cyc(0, 0, 0, 0, 0, 0); chk("gate.2", int'(t0) * 10 + int'(o0), 56);
    cyc(0, 0, 0, 0, 0, 1); chk("gate.3", int'(t0) * 10 + int'(o0), 55);
    cyc(0, 0, 0, 0, 0, 0); chk("gate.4", int'(t0) * 10 + int'(o0), 55);
    cyc(0, 0, 0, 0, 1, 1);
    chk("stop.busy", int'(b0), 0);
    chk("stop.value", int'(t0) * 10 + int'(o0), 55);

    // load beats start; start on 00 expires immediately.
    cyc(1, 4, 2, 1, 0, 0);
    chk("load_vs_start.busy", int'(b0), 0);
    chk("load_vs_start.value", int'(t0) * 10 + int'(o0), 42);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("start00.busy", int'(b0), 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("start00.done", int'(d0), 1);

    // Asynchronous reset in the middle of a count.
    cyc(1, 3, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    repeat (5) cyc(0, 0, 0, 0, 0, 1);
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    chk("async_rst.value", int'(t0) * 10 + int'(o0), 99);
    @(posedge clk);
    @(negedge clk);
    check_all();
    chk("async_rst.done", int'(d0), 0);
    rst = 1'b0;

    // Random traffic against the reference.
    for (int k = 0; k < 3000; k++) begin
      logic l, s, sp, ce;
      int lt, lo;
      l  = ($urandom_range(0, 19) == 0);
      s  = ($urandom_range(0, 5) == 0);
      sp = ($urandom_range(0, 29) == 0);
      ce = ($urandom_range(0, 2) != 0);
      lt = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      lo = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) lt = 0;
      cyc(l, lt, lo, s, sp, ce);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
